// File: rtl/addr_bus_pkg.sv
// Shared definitions for the address-low bus driver.
//   IDLE_*   : encodings for the IDLE_MODE parameter (bus value with no driver)
//   sat_inc  : saturating increment for counters of any width up to 32 bits
package addr_bus_pkg;

  localparam int IDLE_ZERO      = 0;
  localparam int IDLE_PRECHARGE = 1;
  localparam int IDLE_HOLD      = 2;

  // Returns value+1 unless value already sits at the all-ones ceiling of a
  // counter that is `width` bits wide; then it stays put (no wrap).
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/bus_priority_mux.sv
// Fixed-priority bus source selector.
//   src_en_i   : per-source drive enable, index 0 has highest priority
//   src_data_i : source i occupies bits [i*WIDTH +: WIDTH]
//   raw_o      : data of the winning source, 0 when nobody drives
//   any_en_o   : at least one source is enabled
//   multi_en_o : two or more sources are enabled (driver conflict)
module bus_priority_mux #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]       src_en_i,
  input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
  output logic [WIDTH-1:0]         raw_o,
  output logic                     any_en_o,
  output logic                     multi_en_o
);

  // Scan from the lowest priority upward so the lowest enabled index is the
  // last assignment and therefore wins.
  always_comb begin
    raw_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_en_i[i]) raw_o = src_data_i[i*WIDTH +: WIDTH];
    end
  end

  assign any_en_o = |src_en_i;

  generate
    if (NUM_SRC == 1) begin : g_single
      assign multi_en_o = 1'b0;
    end else begin : g_multi
      always_comb begin
        logic found;
        found      = 1'b0;
        multi_en_o = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (src_en_i[i]) begin
            if (found) multi_en_o = 1'b1;
            found = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/address_low_bus_latched.sv
// Address-low bus driver with output latch and conflict monitor.
//   clk, rst        : clock, synchronous active-high reset
//   src_en/src_data : per-source enables and packed source data
//   zero_mask       : bit k forces adl[k] low (k < ZERO_BITS)
//   abl_load        : capture adl into abl at the next edge
//   conflict_clr    : clear sticky flag and counter
//   adl             : combinational bus value
//   abl             : registered address-low output
//   conflict        : two or more sources enabled this cycle
//   conflict_sticky : set by any conflict until cleared
//   conflict_count  : saturating count of conflict cycles
// No valid/ready handshake: every input is sampled on every clock edge.
module address_low_bus_latched
  import addr_bus_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_SRC   = 4,
  parameter int ZERO_BITS = 3,
  parameter int IDLE_MODE = IDLE_ZERO,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_en,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [ZERO_BITS-1:0]     zero_mask,
  input  logic                     abl_load,
  input  logic                     conflict_clr,
  output logic [WIDTH-1:0]         adl,
  output logic [WIDTH-1:0]         abl,
  output logic                     conflict,
  output logic                     conflict_sticky,
  output logic [CNT_WIDTH-1:0]     conflict_count
);

  logic [WIDTH-1:0]     mux_raw;
  logic                 any_en;
  logic                 multi_en;
  logic [WIDTH-1:0]     keeper_q;
  logic [WIDTH-1:0]     idle_val;
  logic [WIDTH-1:0]     raw;
  logic [WIDTH-1:0]     zero_ext;
  logic [WIDTH-1:0]     abl_q;
  logic                 sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  bus_priority_mux #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC)
  ) u_mux (
    .src_en_i   (src_en),
    .src_data_i (src_data),
    .raw_o      (mux_raw),
    .any_en_o   (any_en),
    .multi_en_o (multi_en)
  );

  // The keeper remembers the last driven value before zeroing, so a masked
  // idle bus still restores the full value once the mask is released.
  generate
    if (IDLE_MODE == IDLE_HOLD) begin : g_keeper
      always_ff @(posedge clk) begin
        if (rst)         keeper_q <= '0;
        else if (any_en) keeper_q <= mux_raw;
      end
    end else begin : g_no_keeper
      assign keeper_q = '0;
    end
  endgenerate

  always_comb begin
    case (IDLE_MODE)
      IDLE_PRECHARGE: idle_val = '1;
      IDLE_HOLD:      idle_val = keeper_q;
      default:        idle_val = '0;
    endcase
  end

  assign raw      = any_en ? mux_raw : idle_val;
  assign zero_ext = WIDTH'(zero_mask);
  assign adl      = raw & ~zero_ext;
  assign conflict = multi_en;

  // A conflict in the same cycle as a clear is kept as the first new event.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (conflict_clr) begin
      sticky_d = conflict;
      cnt_d    = conflict ? CNT_WIDTH'(1) : '0;
    end else if (conflict) begin
      sticky_d = 1'b1;
      cnt_d    = CNT_WIDTH'(sat_inc(32'(cnt_q), CNT_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abl_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (abl_load) abl_q <= adl;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign abl             = abl_q;
  assign conflict_sticky = sticky_q;
  assign conflict_count  = cnt_q;

endmodule

// File: doc/address_low_bus_latched.md
Name: address_low_bus_latched

Overview:
Parametrised successor to the CPU address-low bus driver. It selects one of NUM_SRC sources by fixed priority and applies per-bit forced-zero control to the low ZERO_BITS bits, giving the combinational internal bus ADL. It adds an idle-bus policy, an address-bus-low output register (ABL) with a load strobe, and multi-driver conflict detection with a sticky flag and a saturating counter. It sits between the CPU datapath registers and the external address pins.

Parameters:
WIDTH, 8, bus width in bits
NUM_SRC, 4, number of bus sources; index 0 has highest priority
ZERO_BITS, 3, number of low bits with an individual force-zero control; ZERO_BITS must be at most WIDTH
IDLE_MODE, 0, bus value when no source is enabled: 0 = all zeros, 1 = precharge all ones, 2 = hold last driven value
CNT_WIDTH, 8, width of the conflict counter

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
src_en  in  NUM_SRC  per-source drive enable
src_data  in  NUM_SRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
zero_mask  in  ZERO_BITS  bit k=1 forces adl[k] to 0
abl_load  in  1  capture adl into abl at the next clock edge
conflict_clr  in  1  clear conflict_sticky and conflict_count
adl  out  WIDTH  combinational bus value
abl  out  WIDTH  registered address-low output
conflict  out  1  combinational; two or more src_en bits are set this cycle
conflict_sticky  out  1  registered; set on any conflict
conflict_count  out  CNT_WIDTH  registered, saturating count of conflict cycles

Behaviour:
- Clock and reset: single clock, clk; rst is synchronous and active-high.
- Reset values: abl=0, keeper=0, conflict_sticky=0, conflict_count=0. rst has priority over abl_load and conflict_clr in the same cycle.
- Source selection (combinational): raw = src_data of the lowest-index source whose src_en is set. If no src_en bit is set, raw depends on IDLE_MODE:
  - 0: raw = 0
  - 1: raw = all ones
  - 2: raw = keeper
- Zeroing (applied after selection): adl[k] = raw[k] & ~zero_mask[k] for k < ZERO_BITS; upper bits pass through unchanged. Zeroing also applies to idle values.
- Keeper register: captures raw (the value before zeroing) at every edge where any src_en is set, and holds otherwise. The register exists only when IDLE_MODE = 2; in the other modes it may be optimised away.
- ABL register: abl <= adl at the edge where abl_load=1; otherwise it holds. adl has zero-cycle latency; abl has one-cycle latency.
- conflict = popcount(src_en) >= 2. Priority resolution still applies, so the lowest index wins.
- Sticky flag and counter, per edge:
  - conflict_clr=1 and conflict=0: sticky 0, count 0
  - conflict_clr=1 and conflict=1: sticky 1, count 1 (the new event survives the clear)
  - otherwise, on conflict: sticky 1, count +1, saturating at 2^CNT_WIDTH-1 with no wrap
- Reset mid-operation: all registers return to their reset values on the next edge. adl continues to reflect the current inputs, so in IDLE_MODE=2 an idle bus reads 0 after reset.
- NUM_SRC=1: conflict is tied to 0.

Decomposition:
- Package addr_bus_pkg holds:
  - IDLE_ZERO=0, IDLE_PRECHARGE=1, IDLE_HOLD=2 localparams (or an enum)
  - a function for the saturating increment
- One sub-module, bus_priority_mux, parametrised on WIDTH and NUM_SRC. Outputs: raw data, any_en, multi_en.
- The top level adds the zeroing, the keeper, ABL, and the conflict logic.

Test Plan:
- Reset: assert rst for 2 cycles with abl_load=1 and src_en=0001, data 0x5A -> abl=0x00, sticky=0, count=0 during reset; after release, adl=0x5A and abl=0x5A one edge later.
- Priority and conflict: src_en=0110, src1=0x12, src2=0x34 -> adl=0x12, conflict=1; after the edge, sticky=1 and count=1; hold for 3 more cycles -> count=4.
- Zeroing: src0=0xFF, zero_mask=101 -> adl=0xFA; zero_mask=111 -> adl=0xF8; with IDLE_MODE=1, src_en=0 and zero_mask=010 -> adl=0xFD.
- Hold mode (IDLE_MODE=2): drive src3=0xA7 for one cycle, then src_en=0 -> adl=0xA7 on subsequent cycles; zero_mask=001 -> adl=0xA6 while the keeper stays 0xA7.
- Saturation and clear (CNT_WIDTH=2): 5 consecutive conflict cycles -> count=3. conflict_clr without conflict -> count=0, sticky=0. conflict_clr together with conflict -> count=1, sticky=1.
- ABL hold: abl_load pulses once with adl=0x3C, then adl changes to 0x99 with abl_load=0 -> abl stays 0x3C.
